// File: rtl/bht_access_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bht_access_scheduler
//  Description : Sole owner of a single-ported 2-bit branch history table.
//                Clears the table after reset, then arbitrates prediction
//                lookups against queued read-modify-write counter updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module bht_access_scheduler #(
    parameter int INDEX_WIDTH = 10,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lookup_valid,
    input  logic [INDEX_WIDTH-1:0] lookup_index,
    output logic                   lookup_ready,
    output logic                   pred_valid,
    output logic [1:0]             pred_state,
    output logic                   pred_taken,
    input  logic                   resolve_valid,
    input  logic [INDEX_WIDTH-1:0] resolve_index,
    input  logic                   resolve_taken,
    output logic                   resolve_ready,
    output logic                   init_busy,
    output logic                   tbl_en,
    output logic                   tbl_we,
    output logic [INDEX_WIDTH-1:0] tbl_addr,
    output logic [1:0]             tbl_wdata,
    input  logic [1:0]             tbl_rdata
);

    localparam int                     c_ptr_w      = $clog2(QUEUE_DEPTH);
    localparam logic [c_ptr_w:0]       c_depth      = (c_ptr_w + 1)'(QUEUE_DEPTH);
    localparam logic [INDEX_WIDTH-1:0] c_last_index = '1;
    localparam logic [1:0]             c_weak_nt    = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [INDEX_WIDTH-1:0] r_sweep_cnt;

    // Pending-update FIFO
    logic [INDEX_WIDTH-1:0] r_q_index [QUEUE_DEPTH];
    logic                   r_q_taken [QUEUE_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_ptr_w:0]       r_count;

    logic                   r_pred_valid;
    logic [1:0]             r_pred_hold;

    logic                   w_full;
    logic                   w_enq;
    logic                   w_deq;
    logic                   w_lookup_acc;
    logic [INDEX_WIDTH-1:0] w_head_index;
    logic                   w_head_taken;
    logic [1:0]             w_sat_next;

    assign w_full        = (r_count == c_depth);
    assign resolve_ready = (r_state != ST_INIT) && (r_count < c_depth);
    assign w_enq         = resolve_valid && resolve_ready;
    assign w_head_index  = r_q_index[r_rd_ptr];
    assign w_head_taken  = r_q_taken[r_rd_ptr];
    assign init_busy     = (r_state == ST_INIT);

    // The read result arrives combinationally in the cycle after the lookup;
    // outside that cycle the last prediction is replayed from the hold reg.
    assign pred_valid    = r_pred_valid;
    assign pred_state    = r_pred_valid ? tbl_rdata : r_pred_hold;
    assign pred_taken    = pred_state[1];

    // Saturating 2-bit counter step for the head update
    always_comb begin
        w_sat_next = tbl_rdata;
        if (w_head_taken) begin
            if (tbl_rdata != 2'b11) w_sat_next = tbl_rdata + 2'b01;
        end else begin
            if (tbl_rdata != 2'b00) w_sat_next = tbl_rdata - 2'b01;
        end
    end

    // State register and sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_sweep_cnt <= r_sweep_cnt + 1'b1;
        end
    end

    // Next-state decode and table port / handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        tbl_en       = 1'b0;
        tbl_we       = 1'b0;
        tbl_addr     = '0;
        tbl_wdata    = 2'b00;
        lookup_ready = 1'b0;
        w_lookup_acc = 1'b0;
        w_deq        = 1'b0;
        case (r_state)
            ST_INIT: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = r_sweep_cnt;
                tbl_wdata = c_weak_nt;
                if (r_sweep_cnt == c_last_index) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                // A full queue must drain first, otherwise lookups win
                if (w_full) begin
                    w_state_nxt = ST_UPD_RD;
                end else if (lookup_valid) begin
                    lookup_ready = 1'b1;
                    w_lookup_acc = 1'b1;
                    tbl_en       = 1'b1;
                    tbl_addr     = lookup_index;
                end else if (r_count != '0) begin
                    w_state_nxt = ST_UPD_RD;
                end
            end
            ST_UPD_RD: begin
                tbl_en      = 1'b1;
                tbl_addr    = w_head_index;
                w_state_nxt = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                tbl_en      = 1'b1;
                tbl_we      = 1'b1;
                tbl_addr    = w_head_index;
                tbl_wdata   = w_sat_next;
                w_deq       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_index[r_wr_ptr] <= resolve_index;
            r_q_taken[r_wr_ptr] <= resolve_taken;
        end
    end

    // Prediction pulse and last-value hold; reset drops any owed pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_hold  <= 2'b00;
        end else begin
            r_pred_valid <= w_lookup_acc;
            if (r_pred_valid) r_pred_hold <= tbl_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bht_access_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bht_access_scheduler
//  Description : Directed scoreboard bench for bht_access_scheduler with a
//                registered-read table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bht_access_scheduler;

    localparam int IW = 4;
    localparam int QD = 4;
    localparam int NENT = 1 << IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_valid;
    logic [IW-1:0] lookup_index;
    logic          lookup_ready;
    logic          pred_valid;
    logic [1:0]    pred_state;
    logic          pred_taken;
    logic          resolve_valid;
    logic [IW-1:0] resolve_index;
    logic          resolve_taken;
    logic          resolve_ready;
    logic          init_busy;
    logic          tbl_en;
    logic          tbl_we;
    logic [IW-1:0] tbl_addr;
    logic [1:0]    tbl_wdata;
    logic [1:0]    tbl_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]      mem   [NENT];
    logic [1:0]      model [NENT];
    logic [IW+1:0]   exp_wr[$];
    logic [1:0]      exp_pred[$];
    int              sweep_cnt = 0;

    bht_access_scheduler #(.INDEX_WIDTH(IW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_index(lookup_index),
        .lookup_ready(lookup_ready),
        .pred_valid(pred_valid), .pred_state(pred_state), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_index(resolve_index),
        .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
        .init_busy(init_busy),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
    );

    always #5 clk = ~clk;

    // Single-port table with registered read data
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= mem[tbl_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Monitor: checks the sweep, scores predictions and table writes
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_pred_valid", pred_valid, 0);
            chk("rst_init_busy", init_busy, 1);
            chk("rst_lookup_ready", lookup_ready, 0);
            chk("rst_resolve_ready", resolve_ready, 0);
            exp_wr.delete();
            exp_pred.delete();
            sweep_cnt = 0;
            for (int i = 0; i < NENT; i++) model[i] = 2'b01;
        end else if (init_busy) begin
            chk("sweep_we", {tbl_en, tbl_we}, 2'b11);
            chk("sweep_addr", tbl_addr, sweep_cnt);
            chk("sweep_wdata", tbl_wdata, 2'b01);
            chk("sweep_lookup_ready", lookup_ready, 0);
            chk("sweep_resolve_ready", resolve_ready, 0);
            chk("sweep_pred_valid", pred_valid, 0);
            sweep_cnt++;
        end else begin
            if (sweep_cnt != 0) begin
                chk("sweep_len", sweep_cnt, NENT);
                sweep_cnt = 0;
            end
            if (pred_valid) begin
                chk("pred_expected", exp_pred.size() > 0, 1);
                if (exp_pred.size() > 0) begin
                    logic [1:0] e;
                    e = exp_pred.pop_front();
                    chk("pred_state", pred_state, e);
                    chk("pred_taken", pred_taken, e[1]);
                end
            end
            if (tbl_en && tbl_we) begin
                chk("upd_lookup_ready", lookup_ready, 0);
                chk("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    logic [IW+1:0] w;
                    w = exp_wr.pop_front();
                    chk("write_addr", tbl_addr, w[IW+1:2]);
                    chk("write_data", tbl_wdata, w[1:0]);
                end
            end
            if (tbl_en && !tbl_we && lookup_valid && tbl_addr != lookup_index)
                chk("rd_lookup_ready", lookup_ready, 0);
            if (lookup_valid && lookup_ready) begin
                chk("lookup_port", {tbl_en, tbl_we, tbl_addr}, {2'b10, lookup_index});
                exp_pred.push_back(model[lookup_index]);
            end
            if (resolve_valid && resolve_ready) begin
                model[resolve_index] = ctr_step(model[resolve_index], resolve_taken);
                exp_wr.push_back({resolve_index, model[resolve_index]});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!init_busy) begin
                done = 1'b1;
                break;
            end
            cyc();
        end
        chk("init_timeout", done, 1);
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_wr.size() == 0) begin
                done = 1'b1;
                break;
            end
            cyc();
        end
        chk("drain_timeout", done, 1);
    endtask

    initial begin
        logic hit;
        logic saw_full;
        logic acc;
        int   accepted;
        int   served;

        rst = 1'b1;
        lookup_valid = 1'b0; lookup_index = '0;
        resolve_valid = 1'b0; resolve_index = '0; resolve_taken = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        // Sweep with a lookup already waiting; it is served on the first IDLE cycle
        lookup_valid = 1'b1; lookup_index = 4'd5;
        wait_init();
        chk("first_lookup_ready", lookup_ready, 1);
        chk("first_resolve_ready", resolve_ready, 1);
        cyc();
        lookup_valid = 1'b0;
        chk("first_pred_valid", pred_valid, 1);
        chk("first_pred_state", pred_state, 2'b01);
        chk("first_pred_taken", pred_taken, 0);
        cyc();
        chk("pred_pulse_once", pred_valid, 0);
        chk("pred_hold", pred_state, 2'b01);

        // Idx 5 taken three times: 10, 11, 11
        resolve_valid = 1'b1; resolve_index = 4'd5; resolve_taken = 1'b1;
        repeat (3) cyc();
        resolve_valid = 1'b0;
        wait_drain();
        lookup_valid = 1'b1; lookup_index = 4'd5;
        cyc();
        lookup_valid = 1'b0;
        chk("idx5_pred_state", pred_state, 2'b11);
        chk("idx5_pred_taken", pred_taken, 1);

        // Idx 2 not-taken twice: 00, 00
        resolve_valid = 1'b1; resolve_index = 4'd2; resolve_taken = 1'b0;
        repeat (2) cyc();
        resolve_valid = 1'b0;
        wait_drain();

        // Back-to-back lookups
        lookup_valid = 1'b1; lookup_index = 4'd2;
        cyc();
        lookup_index = 4'd5;
        chk("b2b_pred0", pred_state, 2'b00);
        cyc();
        lookup_valid = 1'b0;
        chk("b2b_valid1", pred_valid, 1);
        chk("b2b_pred1", pred_state, 2'b11);
        cyc();

        // Fill the queue while lookups are continuously requested
        lookup_valid = 1'b1; lookup_index = 4'd9;
        resolve_valid = 1'b1; resolve_index = 4'd3; resolve_taken = 1'b1;
        saw_full = 1'b0; accepted = 0; served = 0;
        for (int i = 0; i < 40 && accepted < 8; i++) begin
            @(negedge clk);
            if (!resolve_ready) saw_full = 1'b1;
            acc = resolve_ready;
            if (lookup_ready) served++;
            cyc();
            if (acc) accepted++;
        end
        resolve_valid = 1'b0;
        lookup_valid = 1'b0;
        chk("fill_accepted", accepted, 8);
        chk("fill_saw_full", saw_full, 1);
        chk("fill_lookups_served", served > 0, 1);
        wait_drain();

        // Reset while an update is writing; the write is abandoned
        resolve_valid = 1'b1; resolve_index = 4'd7; resolve_taken = 1'b1;
        cyc();
        resolve_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tbl_en && tbl_we && !init_busy) begin
                hit = 1'b1;
                break;
            end
            cyc();
        end
        chk("upd_wr_reached", hit, 1);
        rst = 1'b1;
        #1;
        chk("upd_rst_pred_valid", pred_valid, 0);
        repeat (2) cyc();
        rst = 1'b0;
        wait_init();

        // Reset mid-sweep at address 7
        cyc();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (init_busy && tbl_addr == 4'd7) begin
                hit = 1'b1;
                break;
            end
            cyc();
        end
        chk("sweep_addr7_reached", hit, 1);
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        chk("sweep_restart_addr", tbl_addr, 0);
        wait_init();

        // Lookup accepted just before reset owes no pulse afterwards
        lookup_valid = 1'b1; lookup_index = 4'd4;
        cyc();
        rst = 1'b1;
        lookup_valid = 1'b0;
        #1;
        chk("cancel_pred_valid", pred_valid, 0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_pred_valid", pred_valid, 0);
        wait_init();

        // Abandoned update on idx 7 never reached the table
        lookup_valid = 1'b1; lookup_index = 4'd7;
        cyc();
        lookup_valid = 1'b0;
        chk("idx7_after_rst", pred_state, 2'b01);
        cyc();

        chk("end_pred_queue", exp_pred.size(), 0);
        chk("end_write_queue", exp_wr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
